// File: rtl/pc_unit.sv
// Fetch-stage program counter with branch/jump/call/return selection and a
// circular return-address stack; pc_next is the value pc takes at the next edge.
module pc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_ADDR = '0,
  parameter int               INC        = 4,
  parameter int               RAS_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [WIDTH-1:0]               branch_target,
  input  logic                           jump,
  input  logic                           call,
  input  logic [WIDTH-1:0]               jump_target,
  input  logic                           ret,
  output logic [WIDTH-1:0]               pc,
  output logic [WIDTH-1:0]               pc_next,
  output logic [WIDTH-1:0]               pc_plus_inc,
  output logic [$clog2(RAS_DEPTH):0]     ras_count,
  output logic                           ras_empty,
  output logic                           ras_full,
  output logic                           ras_underflow
);

  localparam int               PTR_W = $clog2(RAS_DEPTH);
  localparam int               CNT_W = PTR_W + 1;
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_reg;
  logic [PTR_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             uf_reg, uf_next;
  logic             push;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

  assign pc_plus_inc = pc_reg + INC_W;
  assign ras_empty   = (count_reg == '0);
  assign ras_full    = (count_reg == DEPTH_C);

  // Priority: reset > stall > branch > call/jump > ret > sequential.
  always_comb begin
    pc_next    = pc_plus_inc;
    ptr_next   = ptr_reg;
    count_next = count_reg;
    uf_next    = 1'b0;
    push       = 1'b0;
    if (rst) begin
      pc_next = RESET_ADDR;
    end else if (stall) begin
      pc_next = pc_reg;
    end else if (branch_taken) begin
      pc_next = branch_target;
    end else if (call) begin
      pc_next  = jump_target;
      push     = 1'b1;
      ptr_next = ptr_reg + PTR_W'(1);
      if (!ras_full) count_next = count_reg + CNT_W'(1);
    end else if (jump) begin
      pc_next = jump_target;
    end else if (ret) begin
      if (!ras_empty) begin
        pc_next    = ras_mem[ptr_reg];
        ptr_next   = ptr_reg - PTR_W'(1);
        count_next = count_reg - CNT_W'(1);
      end else begin
        uf_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_ADDR;
      ptr_reg   <= '0;
      count_reg <= '0;
      uf_reg    <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      ptr_reg   <= ptr_next;
      count_reg <= count_next;
      uf_reg    <= uf_next;
    end
  end

  // Stack storage is never cleared; a full push overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (push) ras_mem[ptr_next] <= pc_plus_inc;
  end

  assign pc            = pc_reg;
  assign ras_count     = count_reg;
  assign ras_underflow = uf_reg;

endmodule
